// File: rtl/disp_arbiter.sv
// disp_arbiter
// Decides who drives the shared 4-digit seven-segment display.
// The temperature path owns the display by default. A one-shot alert takes
// over for HOLD_MS, and a GAP_MS guard time follows it. An alert that arrives
// during the guard time is held and granted when the guard time ends.
//
// Optional build macro: DISP_BLINK_EN. When it is defined, an active alert
// alternates between the alert digits and the temperature digits every
// BLINK_MS.
//
// Ports:
//   sys_clk, sys_rst_n   clock and asynchronous active-low reset
//   t_valid, t_digits    strobe and four 4-bit temperature codes
//   t_ack                pulse one cycle after a t_valid
//   a_req, a_digits      alert request (rising edge) and its four codes
//   a_ack                pulse when an alert is granted or restarted
//   a_done               pulse on the last cycle of an alert hold
//   owner                0 = temperature, 1 = alert
//   Num1..Num4           zero-extended digit codes for the display driver
module disp_arbiter #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int HOLD_MS  = 2000,
    parameter int GAP_MS   = 500,
    parameter int BLINK_MS = 250
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        t_valid,
    input  logic [15:0] t_digits,
    output logic        t_ack,
    input  logic        a_req,
    input  logic [15:0] a_digits,
    output logic        a_ack,
    output logic        a_done,
    output logic        owner,
    output logic [7:0]  Num1,
    output logic [7:0]  Num2,
    output logic [7:0]  Num3,
    output logic [7:0]  Num4
);

    localparam int MS_CYC = CLK_HZ / 1000;
    localparam int MS_W   = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam int TM_MAX = (HOLD_MS > GAP_MS) ? HOLD_MS : GAP_MS;
    localparam int TM_W   = $clog2(TM_MAX + 1);

    localparam logic [1:0] S_TEMP  = 2'd0;
    localparam logic [1:0] S_ALERT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    if (HOLD_MS < 1 || GAP_MS < 1 || BLINK_MS < 1 || MS_CYC < 1) begin : g_param_check
        $error("disp_arbiter: timing parameters must give at least one cycle per ms and be >= 1");
    end

    // Any code above 10 ('C') is clamped so the driver never indexes past its table.
    function automatic logic [15:0] sanitize(input logic [15:0] d);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (d[i*4 +: 4] > 4'd10) ? 4'd10 : d[i*4 +: 4];
        end
        return r;
    endfunction

    logic [1:0]      state_q, state_d;
    logic            areq_q;
    logic [MS_W-1:0] ms_q, ms_d;
    logic [TM_W-1:0] tm_q, tm_d;
    logic [15:0]     temp_q;
    logic [15:0]     alert_q, alert_d;
    logic [15:0]     pdig_q, pdig_d;
    logic            pend_q, pend_d;
    logic            a_ack_d, a_done_d;
    logic            req_ev, ms_tick, show_alert;
    logic [15:0]     src;

    assign req_ev  = a_req & ~areq_q;
    assign ms_tick = (ms_q == MS_W'(MS_CYC - 1));

`ifdef DISP_BLINK_EN
    localparam int BL_W = $clog2(BLINK_MS + 1);
    logic [BL_W-1:0] bl_q, bl_d;
    logic            ph_q, ph_d;
`endif

    always_comb begin
        state_d  = state_q;
        alert_d  = alert_q;
        pdig_d   = pdig_q;
        pend_d   = pend_q;
        a_ack_d  = 1'b0;
        a_done_d = 1'b0;
        ms_d     = ms_tick ? '0 : ms_q + MS_W'(1);
        tm_d     = (ms_tick && state_q != S_TEMP) ? tm_q + TM_W'(1) : tm_q;
`ifdef DISP_BLINK_EN
        // Blink phase advances once per BLINK_MS while an alert is shown.
        bl_d = bl_q;
        ph_d = ph_q;
        if (state_q == S_ALERT && ms_tick) begin
            if (bl_q == BL_W'(BLINK_MS - 1)) begin
                bl_d = '0;
                ph_d = ~ph_q;
            end else begin
                bl_d = bl_q + BL_W'(1);
            end
        end
`endif
        case (state_q)
            S_TEMP: begin
                // A fresh edge takes priority over the deferred copy.
                if (req_ev || pend_q) begin
                    alert_d = req_ev ? sanitize(a_digits) : pdig_q;
                    a_ack_d = 1'b1;
                    ms_d    = '0;
                    tm_d    = '0;
                    pend_d  = 1'b0;
                    state_d = S_ALERT;
`ifdef DISP_BLINK_EN
                    bl_d = '0;
                    ph_d = 1'b0;
`endif
                end
            end
            S_ALERT: begin
                if (req_ev) begin
                    alert_d = sanitize(a_digits);
                    a_ack_d = 1'b1;
                    ms_d    = '0;
                    tm_d    = '0;
`ifdef DISP_BLINK_EN
                    bl_d = '0;
                    ph_d = 1'b0;
`endif
                end else if (ms_tick && tm_q == TM_W'(HOLD_MS - 1)) begin
                    a_done_d = 1'b1;
                    ms_d     = '0;
                    tm_d     = '0;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                if (req_ev) begin
                    pend_d = 1'b1;
                    pdig_d = sanitize(a_digits);
                end
                if (ms_tick && tm_q == TM_W'(GAP_MS - 1)) begin
                    tm_d    = '0;
                    state_d = S_TEMP;
                end
            end
            default: state_d = S_TEMP;
        endcase
    end

`ifdef DISP_BLINK_EN
    assign show_alert = (state_q == S_ALERT) && !ph_q;
`else
    assign show_alert = (state_q == S_ALERT);
`endif
    assign src = show_alert ? alert_q : temp_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_TEMP;
            areq_q  <= 1'b0;
            ms_q    <= '0;
            tm_q    <= '0;
            temp_q  <= '0;
            alert_q <= '0;
            pdig_q  <= '0;
            pend_q  <= 1'b0;
            t_ack   <= 1'b0;
            a_ack   <= 1'b0;
            a_done  <= 1'b0;
            owner   <= 1'b0;
            Num1    <= '0;
            Num2    <= '0;
            Num3    <= '0;
            Num4    <= '0;
`ifdef DISP_BLINK_EN
            bl_q    <= '0;
            ph_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            areq_q  <= a_req;
            ms_q    <= ms_d;
            tm_q    <= tm_d;
            alert_q <= alert_d;
            pdig_q  <= pdig_d;
            pend_q  <= pend_d;
            t_ack   <= t_valid;
            a_ack   <= a_ack_d;
            a_done  <= a_done_d;
            if (t_valid) begin
                temp_q <= sanitize(t_digits);
            end
            // Outputs follow the current state and registers one cycle later.
            owner <= (state_q == S_ALERT);
            Num1  <= {4'b0, src[15:12]};
            Num2  <= {4'b0, src[11:8]};
            Num3  <= {4'b0, src[7:4]};
            Num4  <= {4'b0, src[3:0]};
`ifdef DISP_BLINK_EN
            bl_q  <= bl_d;
            ph_q  <= ph_d;
`endif
        end
    end

endmodule

// File: doc/disp_arbiter.md
# disp_arbiter

Arbiter and scheduler for the shared 4-digit 74HC595 seven-segment display. It grants the display's Num1..Num4 digit-code inputs either to the temperature path (background owner) or to a one-shot alert/message requester (priority owner). The alert owns the display for a fixed hold time, followed by a guard gap. It sits between the DS18B20 digit formatter, the alert source, and the display driver.

## Interface
- CLK_HZ, 50_000_000: sys_clk frequency; one millisecond is CLK_HZ/1000 cycles.
- HOLD_MS, 2000: alert display time in ms, ≥1.
- GAP_MS, 500: guard time after an alert during which new alerts are deferred, ≥1.
- BLINK_MS, 250: blink half-period in ms. Used only with DISP_BLINK_EN.
- sys_clk  in  1  single clock; all logic on its rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- t_valid  in  1  one-cycle strobe: new temperature digits on t_digits.
- t_digits  in  16  four 4-bit codes, [15:12]=digit1 … [3:0]=digit4.
- t_ack  out  1  one-cycle pulse, the cycle after a t_valid is accepted.
- a_req  in  1  alert request; the rising edge is the request.
- a_digits  in  16  alert codes, same packing, sampled on the a_req rising edge.
- a_ack  out  1  one-cycle pulse when an alert is granted or restarted.
- a_done  out  1  one-cycle pulse when an alert hold expires.
- owner  out  1  0 = temperature, 1 = alert.
- Num1..Num4  out  8 each  digit code to the display driver; zero-extended 4-bit code.

## Operation
- Codes: 0-9 are digits; 10 is 'C'. Codes 11-15 are forced to 10 on latch, so the driver never sees an out-of-range index.
- Temperature register: loaded on every t_valid, in any state. t_ack pulses in the following cycle. The latest sample is always kept.
- a_req edge detect: a registered previous-value flop. An edge is a request event.
- FSM states and transitions:
  - S_TEMP: shows the temperature register; owner=0. A request event, or a set pending flag → latch a_digits (or the pending copy), pulse a_ack, clear the ms prescaler and hold counter, clear pending, go to S_ALERT.
  - S_ALERT: shows the alert register; owner=1. A request event reloads the digits, pulses a_ack and restarts the full hold. When HOLD_MS ms have elapsed → pulse a_done, go to S_GAP.
  - S_GAP: shows temperature; owner=0. A request event sets pending and stores a_digits; a later event overwrites the stored digits. When GAP_MS ms have elapsed → S_TEMP.
- Simultaneous t_valid and request event: both are accepted in the same cycle.
- Timing base: the ms prescaler runs freely. It is cleared on entry to S_ALERT and on entry to S_GAP, so the hold is exactly HOLD_MS·CLK_HZ/1000 cycles.

## Timing
- Reset values: state S_TEMP; Num1..Num4=0; owner=0; t_ack=0; a_ack=0; a_done=0; pending=0; all registers and counters 0.
- Num and owner are registered and change one cycle after the state or register update. Example: request event at cycle N → a_ack and register load at N+1, Num/owner at N+2.
- t_valid at cycle N → t_ack at N+1; Num at N+2 if the temperature is displayed.
- a_done pulses on the last hold cycle; owner returns to 0 in the next cycle.
- Reset asserted mid-alert or mid-gap: immediate return to the reset values. A pending request is discarded.

## Configuration
- DISP_BLINK_EN defined: in S_ALERT the display alternates every BLINK_MS ms. The alert digits show first, then the temperature digits. The phase restarts on every grant or restart. owner stays 1 throughout.
- DISP_BLINK_EN undefined: the alert digits show steadily for the whole hold, and BLINK_MS is ignored.

## Test plan
(All scenarios use CLK_HZ=10_000, HOLD_MS=3, GAP_MS=2, BLINK_MS=1.)
- Reset, then t_valid with t_digits=16'h0235 → t_ack after 1 cycle; Num1..4=0,2,3,5 after 2 cycles; owner=0.
- a_req edge with a_digits=16'h9999 → a_ack; owner=1 for exactly 30 cycles; a_done on the last of them; temperature shown again afterwards.
- Second edge 15 cycles into the hold, with a_digits=16'h1111 → a_ack, Num=1,1,1,1, hold restarts (a further 30 cycles).
- Edge during S_GAP → no a_ack until the gap ends (20 cycles after a_done), then grant with the stored digits.
- t_digits=16'hFABC with t_valid → Num=10,10,10,10. t_valid during an alert → temperature updated, alert unchanged; the new value shows after a_done.
- With DISP_BLINK_EN: Num toggles between alert and temperature digits every 10 cycles during the hold. Without it: steady alert digits. Reset mid-alert → Num=0, owner=0.
